// File: rtl/vout_pkg.sv
// Shared types and constants for the sequential BCD converter feeding the
// 7-segment display muxer.
package vout_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // One double-dabble step per bit of the 32-bit magnitude register.
   localparam int SHIFT_CYCLES = 32;

   // Largest value representable in `digits` BCD digits: 10^digits - 1.
   // 33 bits wide so it compares directly against the 33-bit magnitude.
   function automatic logic [32:0] bcd_max(input int digits);
      logic [32:0] p;
      p = 33'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 33'd10;
      end
      return p - 33'd1;
   endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next digit.
module bcd_nibble_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);

   // Add-3-if-greater-or-equal-5.
   always_comb begin
      q = d;
      if (d >= 4'd5) begin
         q = d + 4'd3;
      end
   end

endmodule

// File: rtl/vout_bcd_conv.sv
// Signed 32-bit to sign / saturated packed-BCD converter for the display
// muxer. Bit-serial double-dabble, one magnitude bit per clock; results are
// published together with a one-cycle bcd_valid pulse.
//
// Optional build macro VOUT_BCD_BLANK_EN adds the `blank` output, which flags
// leading-zero digits (digit 0 is never blanked).
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// LOAD  | sign, absolute value and saturation of the captured value
// SHIFT | 32 shift-add-3 steps into the BCD accumulator
// DONE  | publish bcd/neg/ovf, pulse bcd_valid, drop busy
module vout_bcd_conv
   import vout_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [31:0]    value,
   input  logic                  start,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg,
   output logic                  ovf,
   output logic                  bcd_valid
`ifdef VOUT_BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int          BCD_W  = 4 * DIGITS;
   localparam logic [32:0] MAXVAL = bcd_max(DIGITS);

   state_t             state;
   state_t             state_nxt;
   logic [31:0]        hold;
   logic [31:0]        sh;
   logic [BCD_W-1:0]   acc;
   logic [BCD_W-1:0]   acc_adj;
   logic [4:0]         cnt;
   logic               neg_r;
   logic               ovf_r;
   logic [32:0]        mag_abs;
   logic [31:0]        mag_sat;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only looked at in IDLE so it is ignored while busy.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (cnt == 5'(SHIFT_CYCLES - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Absolute value in 33 bits so -2^31 maps to +2^31, then clamp to the
   // largest displayable value; the clamp also keeps every digit below 10.
   always_comb begin
      mag_abs = hold[31] ? (33'd0 - {hold[31], hold}) : {1'b0, hold};
      mag_sat = (mag_abs > MAXVAL) ? MAXVAL[31:0] : mag_abs[31:0];
   end

   // One correction cell per digit of the accumulator.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
         .d (acc[4*g +: 4]),
         .q (acc_adj[4*g +: 4])
      );
   end

`ifdef VOUT_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              zero_run;

   // A digit blanks only if it and everything above it are zero.
   always_comb begin
      blank_nxt = '0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run & (acc[4*i +: 4] == 4'd0);
         blank_nxt[i] = zero_run;
      end
   end
`endif

   // Datapath and published outputs; outputs only change in DONE so the
   // display never sees a partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold      <= '0;
         sh        <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg_r     <= 1'b0;
         ovf_r     <= 1'b0;
         busy      <= 1'b0;
         bcd       <= '0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         bcd_valid <= 1'b0;
`ifdef VOUT_BCD_BLANK_EN
         blank     <= '0;
`endif
      end else begin
         bcd_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  hold <= value;
                  busy <= 1'b1;
               end
            end
            LOAD: begin
               neg_r <= hold[31];
               ovf_r <= (mag_abs > MAXVAL);
               sh    <= mag_sat;
               acc   <= '0;
               cnt   <= '0;
            end
            SHIFT: begin
               {acc, sh} <= {acc_adj, sh} << 1;
               cnt       <= cnt + 5'd1;
            end
            DONE: begin
               bcd       <= acc;
               neg       <= neg_r;
               ovf       <= ovf_r;
               bcd_valid <= 1'b1;
               busy      <= 1'b0;
`ifdef VOUT_BCD_BLANK_EN
               blank     <= blank_nxt;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vout_bcd_conv.sv
// Bench for vout_bcd_conv: a 4-digit and an 8-digit instance, directed
// corner cases plus random values, checked against a decimal reference model.
module tb_vout_bcd_conv;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value4, value8;
   logic        start4, start8;
   logic        busy4, neg4, ovf4, valid4;
   logic        busy8, neg8, ovf8, valid8;
   logic [15:0] bcd4;
   logic [31:0] bcd8;
`ifdef VOUT_BCD_BLANK_EN
   logic [3:0]  blank4;
   logic [7:0]  blank8;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vout_bcd_conv #(.DIGITS(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .value     (value4),
      .start     (start4),
      .busy      (busy4),
      .bcd       (bcd4),
      .neg       (neg4),
      .ovf       (ovf4),
      .bcd_valid (valid4)
`ifdef VOUT_BCD_BLANK_EN
      ,
      .blank     (blank4)
`endif
   );

   vout_bcd_conv #(.DIGITS(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .value     (value8),
      .start     (start8),
      .busy      (busy8),
      .bcd       (bcd8),
      .neg       (neg8),
      .ovf       (ovf8),
      .bcd_valid (valid8)
`ifdef VOUT_BCD_BLANK_EN
      ,
      .blank     (blank8)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: sign, |v| saturated to 10^digits-1, digits by mod/div.
   task automatic ref_model(input logic [31:0] v, input int digits,
                            output logic [31:0] b, output logic n, output logic o,
                            output logic [7:0] bl);
      longint m, mx;
      logic   run;
      n  = v[31];
      m  = longint'($signed(v));
      if (m < 0) m = -m;
      mx = 1;
      for (int i = 0; i < digits; i++) mx = mx * 10;
      mx = mx - 1;
      o  = (m > mx);
      if (o) m = mx;
      b = '0;
      for (int i = 0; i < digits; i++) begin
         b[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      bl  = '0;
      run = 1'b1;
      for (int i = digits - 1; i >= 1; i--) begin
         run   = run && (b[4*i +: 4] == 4'd0);
         bl[i] = run;
      end
   endtask

   task automatic get_out(input int sel, output logic [31:0] b, output logic n,
                          output logic o, output logic vld, output logic bz,
                          output logic [7:0] bl);
      bl = '0;
      if (sel == 0) begin
         b = {16'h0, bcd4}; n = neg4; o = ovf4; vld = valid4; bz = busy4;
`ifdef VOUT_BCD_BLANK_EN
         bl = {4'h0, blank4};
`endif
      end else begin
         b = bcd8; n = neg8; o = ovf8; vld = valid8; bz = busy8;
`ifdef VOUT_BCD_BLANK_EN
         bl = blank8;
`endif
      end
   endtask

   // Present value with start for one edge; returns #1 after the accepting edge.
   task automatic accept(input int sel, input logic [31:0] v);
      if (sel == 0) begin value4 = v; start4 = 1'b1; end
      else          begin value8 = v; start8 = 1'b1; end
      @(posedge clk); #1;
      start4 = 1'b0;
      start8 = 1'b0;
      if (sel == 0) check("busy_after_accept", busy4, 1'b1);
      else          check("busy_after_accept", busy8, 1'b1);
   endtask

   // Waits for bcd_valid (bounded), checks latency, stability and result.
   task automatic wait_result(input int sel, input logic [31:0] v, input int elapsed,
                              input string tag);
      logic [31:0] b, pb, eb;
      logic        n, o, vld, bz, pn, po, en, eo;
      logic [7:0]  bl, pbl, ebl;
      int          k;
      bit          stable, got;
      get_out(sel, pb, pn, po, vld, bz, pbl);
      k = elapsed; stable = 1'b1; got = 1'b0;
      while (k < 60 && !got) begin
         @(posedge clk); #1;
         k++;
         get_out(sel, b, n, o, vld, bz, bl);
         if (vld) got = 1'b1;
         else if (b !== pb || n !== pn || o !== po) stable = 1'b0;
      end
      ref_model(v, (sel == 0) ? 4 : 8, eb, en, eo, ebl);
      check({tag, ".latency"}, k, 34);
      check({tag, ".stable"}, stable, 1'b1);
      check({tag, ".bcd"}, b, eb);
      check({tag, ".neg"}, n, en);
      check({tag, ".ovf"}, o, eo);
      check({tag, ".busy_low"}, bz, 1'b0);
`ifdef VOUT_BCD_BLANK_EN
      check({tag, ".blank"}, bl, ebl);
`endif
   endtask

   task automatic pulse_end(input int sel, input string tag);
      @(posedge clk); #1;
      check({tag, ".pulse1"}, (sel == 0) ? valid4 : valid8, 1'b0);
   endtask

   task automatic convert(input int sel, input logic [31:0] v, input string tag);
      accept(sel, v);
      wait_result(sel, v, 0, tag);
      pulse_end(sel, tag);
   endtask

   task automatic count_valids(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (valid4 || valid8) cnt++;
      end
   endtask

   function automatic logic [31:0] rand_val(input int sel);
      logic [31:0] r;
      case ($urandom_range(0, 3))
         0: r = $urandom_range(0, (sel == 0) ? 9999 : 99999999);
         1: r = $urandom_range(0, (sel == 0) ? 15000 : 150000000);
         2: r = $urandom;
         default: begin
            case ($urandom_range(0, 5))
               0: r = 32'h8000_0000;
               1: r = 32'h7fff_ffff;
               2: r = (sel == 0) ? 32'd9999 : 32'd99999999;
               3: r = (sel == 0) ? 32'd10000 : 32'd100000000;
               4: r = 32'd0;
               default: r = 32'hffff_ffff;
            endcase
         end
      endcase
      if ($urandom_range(0, 1) == 1 && r != 32'h8000_0000) r = -r;
      return r;
   endfunction

   initial begin
      int nv;
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0; value4 = '0; value8 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.bcd4", bcd4, 16'h0);
      check("rst.busy4", busy4, 1'b0);
      check("rst.valid4", valid4, 1'b0);
      check("rst.neg_ovf4", {neg4, ovf4}, 2'b00);
      check("rst.bcd8", bcd8, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      convert(0, 32'd1234, "v1234");
      check("v1234.const", bcd4, 16'h1234);
      convert(0, -32'sd56, "vneg56");
      check("vneg56.const", {neg4, bcd4}, {1'b1, 16'h0056});
`ifdef VOUT_BCD_BLANK_EN
      check("vneg56.blank_const", blank4, 4'b1100);
`endif
      convert(0, 32'd10000, "v10000");
      check("v10000.const", {ovf4, bcd4}, {1'b1, 16'h9999});
      convert(0, 32'h8000_0000, "vmin");
      check("vmin.const", {neg4, ovf4, bcd4}, {2'b11, 16'h9999});
      convert(0, 32'd0, "vzero");
      convert(0, 32'd9999, "v9999");

      // start during a conversion is dropped
      accept(0, 32'd42);
      repeat (4) begin @(posedge clk); #1; end
      value4 = 32'd7; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      wait_result(0, 32'd42, 5, "ignore");
      check("ignore.const", bcd4, 16'h0042);
      count_valids(40, nv);
      check("ignore.extra_valid", nv, 0);

      // back-to-back: start in the bcd_valid cycle is accepted
      accept(0, 32'd321);
      wait_result(0, 32'd321, 0, "chainA");
      accept(0, -32'sd8765);
      wait_result(0, -32'sd8765, 0, "chainB");
      pulse_end(0, "chainB");

      // reset in the middle of a conversion
      accept(0, 32'd999);
      repeat (12) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort.bcd", bcd4, 16'h0);
      check("abort.busy", busy4, 1'b0);
      check("abort.neg_ovf", {neg4, ovf4}, 2'b00);
      count_valids(40, nv);
      check("abort.no_valid", nv, 0);
      convert(0, 32'd999, "after_abort");

      convert(1, 32'd99999999, "d8max");
      check("d8max.const", {ovf8, bcd8}, {1'b0, 32'h9999_9999});
      convert(1, 32'd100000000, "d8ovf");
      check("d8ovf.const", ovf8, 1'b1);
      convert(1, -32'sd12345678, "d8neg");

      for (int i = 0; i < 25; i++) convert(0, rand_val(0), "rnd4");
      for (int i = 0; i < 15; i++) convert(1, rand_val(1), "rnd8");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
